// File: rtl/mem_arbiter.sv
// rtl/mem_arbiter.sv - shares one memory port among NREQ req/ack requesters, one access in flight.
// Round-robin by default; define CPU_PRIORITY_EN to give requester 0 absolute priority.
`default_nettype none

module mem_arbiter #(
    parameter int NREQ = 3,
    parameter int AW   = 8,
    parameter int DW   = 8
) (
    input  logic              clk,
    input  logic              rst,
    input  logic [NREQ-1:0]   req,
    input  logic [NREQ-1:0]   we,
    input  logic [NREQ*AW-1:0] addr,
    input  logic [NREQ*DW-1:0] wdata,
    output logic [NREQ-1:0]   ack,
    output logic [DW-1:0]     rdata,
    output logic [2:0]        gnt_id,
    output logic              busy,
    output logic [AW-1:0]     mem_addr,
    output logic [DW-1:0]     mem_wdata,
    output logic              mem_read,
    output logic              mem_write,
    input  logic [DW-1:0]     mem_rdata
);

    typedef enum logic [1:0] {
        S_IDLE  = 2'd0,
        S_GRANT = 2'd1,
        S_ACK   = 2'd2
    } state_t;

    state_t      state;
    state_t      state_nxt;
    logic [2:0]  rr_ptr;
    logic [7:0]  req_ext;
    logic [2:0]  win;
    logic        found;
    logic [3:0]  cand;
    logic [AW-1:0] sel_addr;
    logic [DW-1:0] sel_wdata;
    logic        sel_we;
    logic        load_grant;
    logic        finish;
    logic        retire;

    // Zero-extend so any 3-bit candidate index stays in range for small NREQ.
    assign req_ext = 8'(req);

    always_comb begin
        win   = '0;
        found = 1'b0;
        cand  = '0;
`ifdef CPU_PRIORITY_EN
        if (req_ext[0]) begin
            win   = 3'd0;
            found = 1'b1;
        end
`endif
        for (int k = 1; k <= NREQ; k++) begin
            cand = {1'b0, rr_ptr} + 4'(k);
            if (cand >= 4'(NREQ))
                cand = cand - 4'(NREQ);
`ifdef CPU_PRIORITY_EN
            if (!found && (cand != 4'd0) && req_ext[cand[2:0]]) begin
`else
            if (!found && req_ext[cand[2:0]]) begin
`endif
                win   = cand[2:0];
                found = 1'b1;
            end
        end
    end

    always_comb begin
        sel_addr  = '0;
        sel_wdata = '0;
        sel_we    = 1'b0;
        for (int i = 0; i < NREQ; i++) begin
            if (win == 3'(i)) begin
                sel_addr  = addr[i*AW +: AW];
                sel_wdata = wdata[i*DW +: DW];
                sel_we    = we[i];
            end
        end
    end

    always_ff @(posedge clk or posedge rst) begin
        if (rst)
            state <= S_IDLE;
        else
            state <= state_nxt;
    end

    always_comb begin
        state_nxt = state;
        case (state)
            S_IDLE:  if (found) state_nxt = S_GRANT;
            S_GRANT: state_nxt = S_ACK;
            S_ACK:   state_nxt = S_IDLE;
            default: state_nxt = S_IDLE;
        endcase
    end

    always_comb begin
        busy       = 1'b0;
        load_grant = 1'b0;
        finish     = 1'b0;
        retire     = 1'b0;
        case (state)
            S_IDLE:  load_grant = found;
            S_GRANT: begin busy = 1'b1; finish = 1'b1; end
            S_ACK:   begin busy = 1'b1; retire = 1'b1; end
            default: ;
        endcase
    end

    // Strobes and ack default low so each is a single-cycle pulse.
    always_ff @(posedge clk or posedge rst) begin
        if (rst) begin
            ack       <= '0;
            rdata     <= '0;
            gnt_id    <= '0;
            mem_addr  <= '0;
            mem_wdata <= '0;
            mem_read  <= 1'b0;
            mem_write <= 1'b0;
            rr_ptr    <= 3'(NREQ - 1);
        end else begin
            mem_read  <= 1'b0;
            mem_write <= 1'b0;
            ack       <= '0;
            if (load_grant) begin
                gnt_id    <= win;
                mem_addr  <= sel_addr;
                mem_wdata <= sel_wdata;
                mem_read  <= !sel_we;
                mem_write <= sel_we;
            end
            if (finish) begin
                ack <= NREQ'(1) << gnt_id;
                if (mem_read)
                    rdata <= mem_rdata;
            end
            if (retire)
                rr_ptr <= gnt_id;
        end
    end

endmodule

`default_nettype wire

// File: tb/tb_mem_arbiter.sv
// tb/tb_mem_arbiter.sv - scoreboard bench for mem_arbiter with a behavioural memory.
`timescale 1ns/1ps

module tb_mem_arbiter;

    localparam int NREQ = 3;
    localparam int AW   = 8;
    localparam int DW   = 8;

    logic              clk = 1'b0;
    logic              rst;
    logic [NREQ-1:0]   req;
    logic [NREQ-1:0]   we;
    logic [NREQ*AW-1:0] addr;
    logic [NREQ*DW-1:0] wdata;
    logic [NREQ-1:0]   ack;
    logic [DW-1:0]     rdata;
    logic [2:0]        gnt_id;
    logic              busy;
    logic [AW-1:0]     mem_addr;
    logic [DW-1:0]     mem_wdata;
    logic              mem_read;
    logic              mem_write;
    logic [DW-1:0]     mem_rdata;

    typedef struct {
        logic [2:0] id;
        logic       wr;
        logic [7:0] a;
        logic [7:0] wd;
        logic [7:0] rd;
    } exp_t;

    exp_t sb[$];
    int   checks   = 0;
    int   failures = 0;
    logic [7:0] mem [256];

    mem_arbiter #(.NREQ(NREQ), .AW(AW), .DW(DW)) dut (
        .clk(clk), .rst(rst), .req(req), .we(we), .addr(addr), .wdata(wdata),
        .ack(ack), .rdata(rdata), .gnt_id(gnt_id), .busy(busy),
        .mem_addr(mem_addr), .mem_wdata(mem_wdata), .mem_read(mem_read),
        .mem_write(mem_write), .mem_rdata(mem_rdata)
    );

    always #5 clk = ~clk;

    assign mem_rdata = mem[mem_addr];

    always @(negedge clk) begin
        if (mem_write)
            mem[mem_addr] = mem_wdata;
    end

    task automatic chk(input string name, input logic [31:0] act, input logic [31:0] exp);
        checks++;
        if (act !== exp) begin
            failures++;
            $display("FAIL %s: got %0h expected %0h at %0t", name, act, exp, $time);
        end
    endtask

    task automatic push(input logic [2:0] id, input logic wr, input logic [7:0] a,
                        input logic [7:0] wd, input logic [7:0] rd);
        exp_t e;
        e.id = id; e.wr = wr; e.a = a; e.wd = wd; e.rd = rd;
        sb.push_back(e);
    endtask

    task automatic wait_acks(input int n, input int budget, output int cyc);
        int seen;
        seen = 0;
        cyc  = 0;
        while (seen < n && cyc < budget) begin
            @(posedge clk);
            #1;
            cyc++;
            if (ack != '0)
                seen++;
        end
        chk("ack_count", 32'(seen), 32'(n));
    endtask

    // Monitor: strobes are checked against the in-flight entry, acks retire it.
    always @(negedge clk) begin
        exp_t e;
        if (!rst) begin
            chk("rw_exclusive", 32'(mem_read & mem_write), 32'd0);
            chk("ack_onehot", 32'($countones(ack) > 1), 32'd0);
            if (mem_read || mem_write) begin
                if (sb.size() == 0) begin
                    checks++; failures++;
                    $display("FAIL strobe_unexpected: addr %0h with empty scoreboard", mem_addr);
                end else begin
                    e = sb[0];
                    chk("strobe_kind", 32'(mem_write), 32'(e.wr));
                    chk("mem_addr", 32'(mem_addr), 32'(e.a));
                    if (e.wr)
                        chk("mem_wdata", 32'(mem_wdata), 32'(e.wd));
                end
            end
            if (ack != '0) begin
                if (sb.size() == 0) begin
                    checks++; failures++;
                    $display("FAIL ack_unexpected: ack %0b with empty scoreboard", ack);
                end else begin
                    e = sb.pop_front();
                    chk("ack_vector", 32'(ack), 32'(3'b001 << e.id));
                    chk("gnt_id", 32'(gnt_id), 32'(e.id));
                    chk("rdata", 32'(rdata), 32'(e.rd));
                end
            end
        end
    end

    initial begin
        int cyc;
        for (int i = 0; i < 256; i++)
            mem[i] = 8'(i) ^ 8'h5A;
        mem[8'h10] = 8'hA5;
        rst = 1'b1; req = '0; we = '0; addr = '0; wdata = '0;
        repeat (2) @(posedge clk);
        #1;
        chk("rst_ack", 32'(ack), 32'd0);
        chk("rst_rdata", 32'(rdata), 32'd0);
        chk("rst_gnt_id", 32'(gnt_id), 32'd0);
        chk("rst_busy", 32'(busy), 32'd0);
        chk("rst_mem_addr", 32'(mem_addr), 32'd0);
        chk("rst_strobes", 32'({mem_read, mem_write}), 32'd0);
        rst = 1'b0;
        @(posedge clk); #1;

        // single read by the CPU
        addr[7:0] = 8'h10;
        push(3'd0, 1'b0, 8'h10, 8'h00, 8'hA5);
        req = 3'b001;
        wait_acks(1, 10, cyc);
        chk("read_latency", 32'(cyc), 32'd2);
        req = '0;
        @(posedge clk); #1;

        // single write by the loader; rdata keeps the last read value
        addr[15:8] = 8'h20; wdata[15:8] = 8'h3C; we = 3'b010;
        push(3'd1, 1'b1, 8'h20, 8'h3C, 8'hA5);
        req = 3'b010;
        wait_acks(1, 10, cyc);
        chk("write_latency", 32'(cyc), 32'd2);
        req = '0; we = '0;
        chk("mem_written", 32'(mem[8'h20]), 32'h3C);
        @(posedge clk); #1;

        // withdrawn request: req[2] high for a single sampling edge
        addr[23:16] = 8'h40;
        push(3'd2, 1'b0, 8'h40, 8'h00, 8'h1A);
        req = 3'b100;
        @(posedge clk); #1;
        req = '0;
        chk("withdraw_busy_grant", 32'(busy), 32'd1);
        wait_acks(1, 10, cyc);
        @(posedge clk); #1;
        chk("withdraw_idle_busy", 32'(busy), 32'd0);
        chk("withdraw_idle_ack", 32'(ack), 32'd0);

        // fairness / priority from a fresh reset (pointer back at NREQ-1)
        rst = 1'b1;
        @(posedge clk); #1;
        rst = 1'b0;
        addr = {8'h32, 8'h31, 8'h30};
`ifdef CPU_PRIORITY_EN
        push(3'd0, 1'b0, 8'h30, 8'h00, 8'h6A);
        push(3'd0, 1'b0, 8'h30, 8'h00, 8'h6A);
        push(3'd0, 1'b0, 8'h30, 8'h00, 8'h6A);
        push(3'd1, 1'b0, 8'h31, 8'h00, 8'h6B);
        push(3'd2, 1'b0, 8'h32, 8'h00, 8'h68);
        push(3'd1, 1'b0, 8'h31, 8'h00, 8'h6B);
        push(3'd2, 1'b0, 8'h32, 8'h00, 8'h68);
        req = 3'b111;
        wait_acks(3, 30, cyc);
        req = 3'b110;
        wait_acks(4, 30, cyc);
        req = '0;
`else
        for (int r = 0; r < 2; r++) begin
            push(3'd0, 1'b0, 8'h30, 8'h00, 8'h6A);
            push(3'd1, 1'b0, 8'h31, 8'h00, 8'h6B);
            push(3'd2, 1'b0, 8'h32, 8'h00, 8'h68);
        end
        req = 3'b111;
        wait_acks(6, 40, cyc);
        req = '0;
`endif
        repeat (2) @(posedge clk);
        #1;

        // asynchronous reset in the middle of a write grant
        addr[15:8] = 8'h55; wdata[15:8] = 8'h77; we = 3'b010;
        req = 3'b010;
        @(posedge clk); #1;
        chk("pre_rst_mem_write", 32'(mem_write), 32'd1);
        chk("pre_rst_busy", 32'(busy), 32'd1);
        rst = 1'b1;
        #1;
        chk("async_rst_mem_write", 32'(mem_write), 32'd0);
        chk("async_rst_ack", 32'(ack), 32'd0);
        chk("async_rst_busy", 32'(busy), 32'd0);
        chk("async_rst_mem_addr", 32'(mem_addr), 32'd0);
        req = '0; we = '0;
        @(posedge clk); #1;
        rst = 1'b0;
        repeat (3) @(posedge clk);
        #1;
        chk("aborted_write_mem", 32'(mem[8'h55]), 32'h0F);
        chk("scoreboard_drained", 32'(sb.size()), 32'd0);

        $display("TB_RESULT checks=%0d failures=%0d", checks, failures);
        $finish;
    end

    initial begin
        #100000;
        $display("FAIL timeout: bench did not finish");
        $fatal(1, "timeout");
    end

endmodule
